// File: rtl/wishbone_arbiter_pkg.sv
// Shared FSM encoding and sizing helper for the round-robin Wishbone arbiter.
package wishbone_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TOUT  = 2'd2
    } arb_state_e;

    function automatic int unsigned wd_width(input int unsigned max_cnt);
        return $clog2(max_cnt + 32'd1);
    endfunction

endpackage

// File: rtl/wishbone_arbiter_rr_picker.sv
// Combinational round-robin picker: first unmasked request after ptr_i wins,
// wrapping back to ptr_i itself as the lowest-priority candidate.
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  mask_i,
    input  logic [IW-1:0] ptr_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    logic [N-1:0] eligible_s;

    assign eligible_s = req_i & ~mask_i;

    // walk ptr+1 .. ptr modulo N, keeping the first eligible hit
    always_comb begin : pick
        int cand;
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr_i) + k) % N;
            if (!valid_o && eligible_s[IW'(cand)]) begin
                valid_o = 1'b1;
                idx_o   = IW'(cand);
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin Wishbone bus arbiter with lock support and an unanswered-strobe
// watchdog that revokes the grant after TIMEOUT stalled cycles.
module wishbone_arbiter
    import wishbone_arb_pkg::*;
#(
    parameter int N_MASTER = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [N_MASTER-1:0]         cyc_i,
    input  logic [N_MASTER-1:0]         stb_i,
    input  logic [N_MASTER-1:0]         lock_i,
    input  logic                        ack_i,
    input  logic                        err_i,
    input  logic                        rty_i,
    output logic [N_MASTER-1:0]         gnt_o,
    output logic [$clog2(N_MASTER)-1:0] owner_o,
    output logic                        busy_o,
    output logic                        timeout_o,
    output logic [$clog2(N_MASTER)-1:0] timeout_id_o
);

    localparam int                  IW      = $clog2(N_MASTER);
    localparam int                  WW      = int'(wd_width(TIMEOUT));
    localparam logic [IW-1:0]       PTR_RST = IW'(N_MASTER - 1);
    localparam logic [WW-1:0]       WD_MAX  = WW'(TIMEOUT);
    localparam logic [N_MASTER-1:0] ONE_HOT = N_MASTER'(1);

    arb_state_e            state_q, state_d;
    logic [N_MASTER-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic                  busy_q, busy_d;
    logic                  tout_q, tout_d;
    logic [IW-1:0]         tout_id_q, tout_id_d;
    logic [WW-1:0]         wd_q, wd_d;
    logic [IW-1:0]         ptr_q, ptr_d;

    logic                  pick_valid_s;
    logic [IW-1:0]         pick_idx_s;
    logic [N_MASTER-1:0]   pick_gnt_s;
    logic                  hold_s;
    logic                  wd_inc_s;

    // One picker serves both idle arbitration (mask empty) and release
    // arbitration (current owner masked); gnt_q is zero outside GRANT.
    rr_picker #(
        .N  (N_MASTER),
        .IW (IW)
    ) u_picker (
        .req_i   (cyc_i),
        .mask_i  (gnt_q),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid_s),
        .idx_o   (pick_idx_s)
    );

    assign pick_gnt_s = ONE_HOT << pick_idx_s;
    assign hold_s     = cyc_i[owner_q] | lock_i[owner_q];
    assign wd_inc_s   = stb_i[owner_q] & ~(ack_i | err_i | rty_i);

    // next-state, grant and watchdog computation
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        busy_d    = busy_q;
        tout_d    = 1'b0;
        tout_id_d = tout_id_q;
        wd_d      = wd_q;
        ptr_d     = ptr_q;
        case (state_q)
            IDLE: begin
                wd_d = '0;
                if (pick_valid_s) begin
                    state_d = GRANT;
                    gnt_d   = pick_gnt_s;
                    owner_d = pick_idx_s;
                    busy_d  = 1'b1;
                    ptr_d   = pick_idx_s;
                end else begin
                    gnt_d   = '0;
                    owner_d = '0;
                    busy_d  = 1'b0;
                end
            end
            GRANT: begin
                // a response in the same cycle clears wd_inc_s, so it beats the timeout
                if (wd_inc_s && (wd_q == WD_MAX)) begin
                    state_d   = TOUT;
                    gnt_d     = '0;
                    owner_d   = '0;
                    busy_d    = 1'b0;
                    tout_d    = 1'b1;
                    tout_id_d = owner_q;
                    wd_d      = '0;
                end else if (hold_s) begin
                    wd_d = wd_inc_s ? (wd_q + WW'(1)) : '0;
                end else if (pick_valid_s) begin
                    gnt_d   = pick_gnt_s;
                    owner_d = pick_idx_s;
                    ptr_d   = pick_idx_s;
                    wd_d    = '0;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    owner_d = '0;
                    busy_d  = 1'b0;
                    wd_d    = '0;
                end
            end
            TOUT: begin
                state_d = IDLE;
                gnt_d   = '0;
                owner_d = '0;
                busy_d  = 1'b0;
                wd_d    = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                owner_d = '0;
                busy_d  = 1'b0;
                wd_d    = '0;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            tout_q    <= 1'b0;
            tout_id_q <= '0;
            wd_q      <= '0;
            ptr_q     <= PTR_RST;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            tout_q    <= tout_d;
            tout_id_q <= tout_id_d;
            wd_q      <= wd_d;
            ptr_q     <= ptr_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign owner_o      = owner_q;
    assign busy_o       = busy_q;
    assign timeout_o    = tout_q;
    assign timeout_id_o = tout_id_q;

endmodule
